// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU adder issue path
package fpu_pkg;
   localparam int EXP_W    = 10;
   localparam int MANT_W   = 21;
   localparam int EXP_BIAS = 511;
   typedef enum logic [3:0] {
      OVERFLOW  = 4'd0,
      UNDERFLOW = 4'd1,
      EXACT     = 4'd2,
      INEXACT   = 4'd3
   } status_t;
   typedef enum logic [1:0] {S_IDLE, S_RESTART, S_WAIT} issue_state_t;
   // The FPU always inserts a hidden 1, so any all-zero exponent must be treated as zero
   function automatic logic is_zero(input logic [31:0] x);
      return x[MANT_W +: EXP_W] == '0;
   endfunction
endpackage

// File: rtl/fpu_operand_fifo.sv
// fpu_operand_fifo: operand pair buffer with wrap-around pointers and occupancy count
module fpu_operand_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign data_o  = mem_q[rd_q];
   // Storage array carries no reset; only the pointers define validity
   always_ff @(posedge clk_i)
      if (push_i) mem_q[wr_q] <= data_i;
   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: buffers operand pairs, restarts the free-running FPU per pair, holds results
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int FPU_LATENCY = 40,
   parameter int CNT_W       = $clog2(FPU_LATENCY)
) (
   input  logic        clock_100Khz,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_op_a,
   input  logic [31:0] in_op_b,
   output logic [31:0] fpu_op_a,
   output logic [31:0] fpu_op_b,
   output logic        fpu_reset_n,
   input  logic [31:0] fpu_data,
   input  logic [3:0]  fpu_status,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_status,
   output logic        out_bypass,
   output logic        busy
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FPU_LATENCY - 1);
   issue_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d, data_q, data_d;
   status_t          status_q, status_d;
   logic             valid_q, valid_d, bypass_q, bypass_d, rst_n_q, rst_n_d, ready_en_q;
   logic             fifo_full, fifo_empty, pop, slot_free, a_zero, b_zero;
   logic [63:0]      fifo_dout;
   logic [31:0]      a, b;

   fpu_operand_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
      .clk_i   (clock_100Khz),
      .rst_i   (reset),
      .push_i  (in_valid && in_ready),
      .pop_i   (pop),
      .data_i  ({in_op_a, in_op_b}),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign a           = fifo_dout[63:32];
   assign b           = fifo_dout[31:0];
   assign a_zero      = is_zero(a);
   assign b_zero      = is_zero(b);
   assign slot_free   = !valid_q || out_ready;
   assign in_ready    = ready_en_q && !fifo_full;
   assign busy        = !fifo_empty || state_q != S_IDLE || valid_q;
   assign fpu_op_a    = op_a_q;
   assign fpu_op_b    = op_b_q;
   assign fpu_reset_n = rst_n_q;
   assign out_valid   = valid_q;
   assign out_data    = data_q;
   assign out_status  = status_q;
   assign out_bypass  = bypass_q;

   // Issue FSM: pop/bypass in IDLE, one-cycle FPU restart, then count out the fixed latency
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      valid_d  = valid_q && !out_ready;
      data_d   = data_q;
      status_d = status_q;
      bypass_d = bypass_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: if (!fifo_empty && slot_free) begin
            pop = 1'b1;
            if (a_zero || b_zero) begin
               valid_d  = 1'b1;
               bypass_d = 1'b1;
               status_d = EXACT;
               data_d   = (a_zero && b_zero) ? {a[31] & b[31], 31'b0} : a_zero ? b : a;
            end else begin
               op_a_d  = a;
               op_b_d  = b;
               state_d = S_RESTART;
            end
         end
         S_RESTART: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: if (cnt_q == LAST) begin
            valid_d  = 1'b1;
            bypass_d = 1'b0;
            data_d   = fpu_data;
            status_d = status_t'(fpu_status);
            state_d  = S_IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      rst_n_d = state_d != S_RESTART;
   end

   // State and output registers; reset also holds the FPU in reset and closes the input
   always_ff @(posedge clock_100Khz) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         status_q   <= EXACT;
         bypass_q   <= 1'b0;
         rst_n_q    <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         status_q   <= status_d;
         bypass_q   <= bypass_d;
         rst_n_q    <= rst_n_d;
         ready_en_q <= 1'b1;
      end
   end

   // With one operation in flight the result slot must be empty when the FPU result lands
   always_ff @(posedge clock_100Khz)
      if (!reset && state_q == S_WAIT && cnt_q == LAST) assert (!valid_q);
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Upstream issue stage for the FPU adder, which uses the 32-bit format {sign, 10-bit exponent with bias 511, 21-bit fraction} and has a free-running internal state machine with no handshake. This block buffers operand pairs behind a valid/ready interface and presents one pair at a time. For each pair it pulses the FPU reset to restart its state machine, waits a fixed latency, then captures data and status into a result register with valid/ready backpressure. Operand pairs containing a zero are resolved locally, because the FPU always inserts a hidden 1.

Parameters:
FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.
FPU_LATENCY, 40, cycles from FPU restart release until its output is valid; at least 2.
CNT_W, $clog2(FPU_LATENCY), latency counter width; derived, do not override.

Ports:
clock_100Khz  in  1  system clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair offered.
in_ready  out  1  FIFO not full.
in_op_a  in  32  operand A.
in_op_b  in  32  operand B.
fpu_op_a  out  32  operand A driven to FPU.
fpu_op_b  out  32  operand B driven to FPU.
fpu_reset_n  out  1  FPU reset, active-low.
fpu_data  in  32  FPU result.
fpu_status  in  4  FPU status_t.
out_valid  out  1  result slot full.
out_ready  in  1  consumer accepts the result.
out_data  out  32  result.
out_status  out  4  status_t.
out_bypass  out  1  result was produced by the zero bypass.
busy  out  1  FIFO non-empty, state not IDLE, or out_valid high.

Behaviour:
- Registered outputs. Reset values: in_ready=0 while reset is high and 1 afterwards; fpu_op_a=fpu_op_b=0; fpu_reset_n=0; out_valid=0; out_data=0; out_status=EXACT; out_bypass=0; busy=0.
- Push: in_valid && in_ready at an edge.
  - in_ready = !full.
  - No fall-through: an entry can be popped no earlier than the edge after its push.
- slot_free = !out_valid || out_ready. A drain and an issue may occur on the same edge.
- FSM states: IDLE, RESTART, WAIT.
- IDLE, when FIFO non-empty and slot_free: pop one pair.
  - Zero bypass: a zero is exponent field [30:21]==0.
    - A zero, B non-zero: out_data = B.
    - B zero, A non-zero: out_data = A.
    - Both zero: out_data = {signA & signB, 31'b0}.
    - In all bypass cases: out_status=EXACT, out_bypass=1, out_valid=1 on the pop edge, state stays IDLE, fpu_reset_n unaffected.
  - Otherwise: latch the pair into fpu_op_a/b, go to RESTART.
- RESTART: fpu_reset_n=0 for exactly one cycle, clear the counter, go to WAIT.
- WAIT: fpu_reset_n=1, counter increments each cycle. When counter==FPU_LATENCY-1:
  - capture out_data=fpu_data and out_status=fpu_status;
  - set out_bypass=0 and out_valid=1;
  - go to IDLE.
- The slot is guaranteed empty at capture, since at most one operation is in flight. This is asserted in simulation.
- Latency from the accepting edge t: bypass results are valid after edge t+1; normal results after edge t+2+FPU_LATENCY.
- fpu_op_a/b hold their values until the next non-bypass pop.
- The result is cleared only when out_valid && out_ready. out_data, out_status and out_bypass stay stable while out_valid is high and out_ready is low.
- Order is strict FIFO across bypass and normal operations.
- Reset mid-operation, at any state:
  - flush the FIFO, state to IDLE, discard the in-flight operation and any held result;
  - fpu_reset_n=0 for the duration of reset;
  - the first post-reset operation restarts the FPU normally.
- Simultaneous push and pop on a non-full FIFO: count unchanged. A push while full cannot occur, because in_ready is low.

Decomposition:
- Shared package fpu_pkg holds:
  - status_t: 4-bit, OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3;
  - EXP_W=10, MANT_W=21, EXP_BIAS=511;
  - the issue FSM state enum.
- Sub-module fpu_operand_fifo: 64-bit wide, FIFO_DEPTH deep, synchronous reset, push/pop/full/empty, wrap-around pointers plus an occupancy counter.

Test Plan:
- Normal op: A=0x3FE00000, B=0x3FE00000, FPU stub returns 0x40000000/EXACT -> fpu_reset_n low exactly 1 cycle; out_valid after edge t+2+FPU_LATENCY; out_data=0x40000000, out_status=EXACT, out_bypass=0.
- Bypass: A=0x00000000, B=0xC0000000 -> out_data=0xC0000000, EXACT, out_bypass=1, valid after edge t+1; fpu_reset_n never pulses.
- Signed zeros: (0x80000000, 0x80000000) -> 0x80000000; (0x80000000, 0x00000000) -> 0x00000000.
- Backpressure: out_ready=0, offer 6 pairs -> exactly FIFO_DEPTH+1=5 accepted, then in_ready low; releasing out_ready drains 5 results in order.
- Back-to-back: out_ready=1, 3 normal pairs -> each drain coincides with the next pop; spacing FPU_LATENCY+2 cycles; no lost or duplicated results.
- Reset mid-WAIT, at counter=10 -> next cycle out_valid=0, busy=0, in_ready=1 after reset deasserts, fpu_reset_n=0 during reset; the stale result never appears.
